// File: rtl/shift_pkg.sv
// Shared definitions for the multicycle shifter.
//   - Operation codes presented on shift_unit.op
//   - FSM state encoding used by shift_unit
//   - is_pass(): identifies codes that copy the operand through unshifted
// Optional feature macro: SHIFT_ROTATE_EN (enables ROL/ROR decoding).
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Codes that are not a recognised shift/rotate finish with the shamt=0 latency.
  function automatic logic is_pass(input logic [2:0] op);
    logic p;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: p = 1'b0;
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR:         p = 1'b0;
`endif
      default:                p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift of a WIDTH-bit word.
// Ports:
//   op       in  3      operation code (shift_pkg OP_*)
//   data_in  in  WIDTH  word to shift
//   data_out out WIDTH  word shifted by exactly one position
// Rotate cases exist only when SHIFT_ROTATE_EN is defined; otherwise those codes
// (and every unrecognised code) return data_in unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic signed [WIDTH-1:0] data_s;

  assign data_s = $signed(data_in);

  always_comb begin
    data_out = data_in;
    case (op)
      OP_SLL: data_out = {data_in[WIDTH-2:0], 1'b0};
      OP_SRL: data_out = {1'b0, data_in[WIDTH-1:1]};
      OP_SRA: data_out = $unsigned(data_s >>> 1);
`ifdef SHIFT_ROTATE_EN
      OP_ROL: data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
      OP_ROR: data_out = {data_in[0], data_in[WIDTH-1:1]};
`endif
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multicycle shifter: latches an operand, shift amount and op on start, then
// shifts the held word one position per clock until the amount is exhausted.
// A one-cycle done pulse marks the final result, which then stays stable until
// the next accepted start.
// Ports:
//   clk      in  1        rising-edge clock
//   reset_n  in  1        synchronous reset, active-low
//   start    in  1        latch data_in/op/shamt and begin (accepted in IDLE or DONE)
//   op       in  3        operation code (shift_pkg OP_*)
//   shamt    in  SHAMT_W  shift amount (0..WIDTH-1)
//   data_in  in  WIDTH    operand
//   result   out WIDTH    shifted value
//   busy     out 1        high while shifting
//   done     out 1        one-cycle completion pulse
// Optional feature macro: SHIFT_ROTATE_EN (ROL/ROR support in shift_step).
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  state_t             state, state_d;
  logic [SHAMT_W-1:0] count, count_d;
  logic [WIDTH-1:0]   result_d;
  logic [WIDTH-1:0]   step_out;
  logic [2:0]         op_q, op_d;
  logic               busy_d, done_d;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op       (op_q),
    .data_in  (result),
    .data_out (step_out)
  );

  always_comb begin
    state_d  = state;
    count_d  = count;
    result_d = result;
    op_d     = op_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state)
      ST_SHIFT: begin
        // start is ignored here; only the latched op and count matter.
        result_d = step_out;
        count_d  = count - 1'b1;
        if (count == SHAMT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE accept a new request identically, which gives
        // back-to-back operation without an idle bubble.
        if (start) begin
          result_d = data_in;
          op_d     = op;
          count_d  = shamt;
          if (shamt == '0 || is_pass(op)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
    end else begin
      state  <= state_d;
      result <= result_d;
      busy   <= busy_d;
      done   <= done_d;
      count  <= count_d;
    end
  end

  // The latched op is only consulted while shifting, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .data_in (data_in),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drives a one-cycle start request.
  task automatic issue(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d);
    start   = 1'b1;
    op      = o;
    shamt   = s;
    data_in = d;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = 32'h0BAD_0BAD;
  endtask

  // Samples at negedges after the accepting edge until done; returns at the
  // negedge where done is high. If intrude_at >= 0, a competing start with
  // different data is driven for one cycle at that sample index.
  task automatic wait_done(input string name, input int lat, input logic [31:0] exp,
                           input int intrude_at);
    int k, bc;
    bit overlap, seen;
    k = 0; bc = 0; overlap = 0; seen = 0;
    while (k <= 40) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && done) overlap = 1;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bc++;
      if (k == intrude_at) begin
        start   = 1'b1;
        op      = OP_SRL;
        shamt   = 5'd1;
        data_in = 32'hFFFF_FFFF;
      end
      k++;
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, k, lat);
    check({name, " busy_cycles"}, bc, lat);
    check({name, " busy_done_overlap"}, 32'(overlap), 32'd0);
    check({name, " result"}, result, exp);
  endtask

  initial begin
    int   cnt;
    logic [31:0] hold;

    vecs[0]  = '{"sll4",      OP_SLL, 5'd4,  32'h0000_0001, 32'h0000_0010, 4};
    vecs[1]  = '{"sra31",     OP_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 31};
    vecs[2]  = '{"srl0",      OP_SRL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
    vecs[3]  = '{"srl31",     OP_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, 31};
    vecs[4]  = '{"sll31",     OP_SLL, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 31};
    vecs[5]  = '{"sra_pos4",  OP_SRA, 5'd4,  32'h7FFF_FFF0, 32'h07FF_FFFF, 4};
    vecs[6]  = '{"srl4",      OP_SRL, 5'd4,  32'hF000_0000, 32'h0F00_0000, 4};
    vecs[7]  = '{"pass_op0",  3'b000, 5'd7,  32'h1234_5678, 32'h1234_5678, 0};
    vecs[8]  = '{"pass_op7",  3'b111, 5'd3,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 0};
    vecs[9]  = '{"sra1",      OP_SRA, 5'd1,  32'h8000_0000, 32'hC000_0000, 1};
`ifdef SHIFT_ROTATE_EN
    vecs[10] = '{"ror1",      OP_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000, 1};
    vecs[11] = '{"rol4",      OP_ROL, 5'd4,  32'h8000_0001, 32'h0000_0018, 4};
`else
    vecs[10] = '{"ror1",      OP_ROR, 5'd1,  32'h0000_0001, 32'h0000_0001, 0};
    vecs[11] = '{"rol4",      OP_ROL, 5'd4,  32'h8000_0001, 32'h8000_0001, 0};
`endif

    reset_n = 1'b0; start = 1'b0; op = '0; shamt = '0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset result", result, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].shamt, vecs[i].data);
      wait_done(vecs[i].name, vecs[i].lat, vecs[i].exp, -1);
      hold = result;
      @(negedge clk);
      check({vecs[i].name, " done_pulse_len"}, 32'(done), 32'd0);
      check({vecs[i].name, " result_held"}, result, hold);
      @(negedge clk);
    end

    // A start while busy is ignored and the first operation completes intact.
    issue(OP_SLL, 5'd8, 32'h0000_0001);
    wait_done("start_in_shift", 8, 32'h0000_0100, 2);
    @(negedge clk);
    check("start_in_shift idle_after", 32'(busy | done), 32'd0);
    @(negedge clk);

    // Back-to-back: new request presented during the DONE cycle.
    issue(OP_SLL, 5'd2, 32'h0000_0001);
    wait_done("b2b_first", 2, 32'h0000_0004, -1);
    issue(OP_SRL, 5'd3, 32'h0000_0100);
    wait_done("b2b_second", 3, 32'h0000_0020, -1);
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a long shift discards it.
    issue(OP_SLL, 5'd20, 32'h0000_0001);
    repeat (5) @(negedge clk);
    check("pre_reset busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_reset result", result, 32'h0);
    check("mid_reset busy", 32'(busy), 32'd0);
    check("mid_reset done", 32'(done), 32'd0);
    reset_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("post_reset no_activity", cnt, 0);
    check("post_reset result", result, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
